// File: rtl/rsa_modexp_core.sv
// rsa_modexp_core: modular exponentiation result = plaintext^key mod mod.
// Right-to-left square-and-multiply built from two bit-serial Blakley
// multipliers running side by side. Every exponent bit costs exactly WIDTH
// cycles, whatever its value, so the run time does not leak the key.
module rsa_modexp_core #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] key,
    input  logic [WIDTH-1:0] mod,
    input  logic [WIDTH-1:0] plaintext,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [WIDTH-1:0] result
);

    localparam int CW = $clog2(WIDTH);
    // Holds 2P + B with P, B < N < 2^WIDTH, so it stays below 3 * 2^WIDTH.
    localparam int PW = WIDTH + 2;

    typedef enum logic [1:0] {IDLE, CHECK, MULT, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] e;
    logic [WIDTH-1:0] n;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] r;
    logic [PW-1:0]    pr;
    logic [PW-1:0]    ps;
    logic [CW-1:0]    i;
    logic [CW-1:0]    j;
    logic [PW-1:0]    pr_next;
    logic [PW-1:0]    ps_next;

    // One interleaved step: shift, conditionally add B, then bring back below N.
    function automatic logic [PW-1:0] blakley_step(
        input logic [PW-1:0]    p,
        input logic             bit_a,
        input logic [WIDTH-1:0] mcand,
        input logic [WIDTH-1:0] modulus
    );
        logic [PW-1:0] t;
        t = {p[PW-2:0], 1'b0} + (bit_a ? PW'(mcand) : '0);
        if (t >= PW'(modulus)) t = t - PW'(modulus);
        if (t >= PW'(modulus)) t = t - PW'(modulus);
        return t;
    endfunction

    // Next accumulator values of the multiply (R*B) and square (B*B) chains.
    always_comb begin
        pr_next = blakley_step(pr, r[i], b, n);
        ps_next = blakley_step(ps, b[i], b, n);
    end

    // Control FSM and datapath registers; all outputs are registered.
    // NOTE: nonblocking assignments here so every register samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            // NOTE: every register, datapath included, is cleared so an aborted run leaves nothing behind.
            state  <= IDLE;
            e      <= '0;
            n      <= '0;
            b      <= '0;
            r      <= '0;
            pr     <= '0;
            ps     <= '0;
            i      <= '0;
            j      <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            error  <= 1'b0;
            result <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    // The done cycle is the tail of DONE: a start seen there is dropped.
                    if (start && !done) begin
                        e     <= key;
                        n     <= mod;
                        b     <= plaintext;
                        error <= 1'b0;
                        busy  <= 1'b1;
                        state <= CHECK;
                    end
                end
                CHECK: begin
                    if (n < WIDTH'(2) || b >= n) begin
                        error <= 1'b1;
                        busy  <= 1'b0;
                        state <= DONE;
                    end else begin
                        r     <= WIDTH'(1);
                        j     <= '0;
                        i     <= CW'(WIDTH - 1);
                        pr    <= '0;
                        ps    <= '0;
                        state <= MULT;
                    end
                end
                MULT: begin
                    if (i == '0) begin
                        // Both products are always computed; only the commit of R depends on E.
                        if (e[j]) r <= pr_next[WIDTH-1:0];
                        b  <= ps_next[WIDTH-1:0];
                        pr <= '0;
                        ps <= '0;
                        if (j == CW'(WIDTH - 1)) begin
                            busy  <= 1'b0;
                            state <= DONE;
                        end else begin
                            j <= j + CW'(1);
                            i <= CW'(WIDTH - 1);
                        end
                    end else begin
                        pr <= pr_next;
                        ps <= ps_next;
                        i  <= i - CW'(1);
                    end
                end
                DONE: begin
                    done   <= 1'b1;
                    result <= error ? '0 : r;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rsa_modexp_core.sv
// tb_rsa_modexp_core: directed and randomized checks of rsa_modexp_core
// against a plain-arithmetic modular exponentiation model.
module tb_rsa_modexp_core;

    localparam int WIDTH   = 32;
    localparam int LAT_OK  = WIDTH * WIDTH + 2;
    localparam int LAT_ERR = 2;

    logic             clock;
    logic             reset;
    logic             start;
    logic [WIDTH-1:0] key;
    logic [WIDTH-1:0] mod;
    logic [WIDTH-1:0] plaintext;
    logic             busy;
    logic             done;
    logic             error;
    logic [WIDTH-1:0] result;

    int tests = 0;
    int fails = 0;

    rsa_modexp_core #(.WIDTH(WIDTH)) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .key       (key),
        .mod       (mod),
        .plaintext (plaintext),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .result    (result)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: base^exp mod n by repeated squaring on 64-bit integers.
    function automatic void model(input logic [WIDTH-1:0] ex, input logic [WIDTH-1:0] nn,
                                  input logic [WIDTH-1:0] bb,
                                  output logic [WIDTH-1:0] res, output logic err);
        longint unsigned acc, base, m;
        if (nn < 2 || bb >= nn) begin
            err = 1'b1;
            res = '0;
            return;
        end
        err  = 1'b0;
        m    = longint'(nn);
        acc  = 1;
        base = longint'(bb);
        for (int k = 0; k < WIDTH; k++) begin
            if (ex[k]) acc = (acc * base) % m;
            base = (base * base) % m;
        end
        res = acc[WIDTH-1:0];
    endfunction

    // Issue one operation and follow it to done. g1/g2 are cycle numbers at
    // which a stray start with fresh operands is pulsed; pulse_in_done also
    // raises start during the done cycle.
    task automatic run_op(input string tag, input logic [WIDTH-1:0] k, input logic [WIDTH-1:0] m,
                          input logic [WIDTH-1:0] p, input logic [WIDTH-1:0] exp_res,
                          input logic exp_err, input int g1, input int g2, input bit pulse_in_done);
        int cyc;
        @(negedge clock);
        start = 1'b1; key = k; mod = m; plaintext = p;
        @(posedge clock);
        cyc = 0;
        @(negedge clock);
        start = 1'b0;
        key = $urandom; mod = $urandom; plaintext = $urandom;
        check({tag, " busy_after_start"}, 64'(busy), 64'd1);
        while (!done && cyc < 3000) begin
            if (cyc == g1 || cyc == g2) begin
                start = 1'b1;
                key = $urandom; mod = $urandom | 32'h2; plaintext = 32'h1;
            end
            @(posedge clock);
            cyc++;
            @(negedge clock);
            start = 1'b0;
        end
        check({tag, " latency"}, 64'(cyc), 64'(exp_err ? LAT_ERR : LAT_OK));
        check({tag, " result"}, 64'(result), 64'(exp_res));
        check({tag, " error"}, 64'(error), 64'(exp_err));
        check({tag, " busy_at_done"}, 64'(busy), 64'd0);
        if (pulse_in_done) begin
            start = 1'b1; key = 32'd3; mod = 32'd3233; plaintext = 32'd2;
            @(posedge clock);
            @(negedge clock);
            start = 1'b0;
            check({tag, " start_in_done_ignored"}, 64'(busy), 64'd0);
            check({tag, " done_single_pulse"}, 64'(done), 64'd0);
            check({tag, " result_held"}, 64'(result), 64'(exp_res));
        end
    endtask

    initial begin
        logic [WIDTH-1:0] rk, rm, rp, er;
        logic             ee;
        int               pulses;

        start = 1'b0; key = '0; mod = '0; plaintext = '0;
        reset = 1'b1;
        repeat (2) @(negedge clock);
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset error", 64'(error), 64'd0);
        check("reset result", 64'(result), 64'd0);
        reset = 1'b0;
        @(negedge clock);

        // Directed vectors.
        run_op("t1", 32'd13, 32'd497, 32'd4, 32'd445, 1'b0, -1, -1, 1'b0);
        run_op("t2_enc", 32'd17, 32'd3233, 32'd65, 32'd2790, 1'b0, -1, -1, 1'b0);
        run_op("t2_dec", 32'd2753, 32'd3233, 32'd2790, 32'd65, 1'b0, -1, -1, 1'b0);
        run_op("t3_key0", 32'd0, 32'd3233, 32'd123, 32'd1, 1'b0, -1, -1, 1'b0);
        run_op("t3_base0", 32'd5, 32'd3233, 32'd0, 32'd0, 1'b0, -1, -1, 1'b0);
        run_op("t4_mod1", 32'd7, 32'd1, 32'd0, 32'd0, 1'b1, -1, -1, 1'b0);
        run_op("t4_b_eq_n", 32'd7, 32'd100, 32'd100, 32'd0, 1'b1, -1, -1, 1'b0);
        run_op("t4_clear", 32'd13, 32'd497, 32'd4, 32'd445, 1'b0, -1, -1, 1'b0);
        run_op("t5_ignore", 32'd17, 32'd3233, 32'd65, 32'd2790, 1'b0, 5, 1025, 1'b1);

        // A start held through done and one more cycle is taken in IDLE.
        @(negedge clock);
        start = 1'b1; key = 32'd3; mod = 32'd3233; plaintext = 32'd2;
        @(negedge clock);
        start = 1'b0;
        check("t5_accept_after_idle", 64'(busy), 64'd1);
        pulses = 0;
        for (int c = 0; c < 3000 && pulses == 0; c++) begin
            @(negedge clock);
            if (done) pulses++;
        end
        check("t5_late_start_result", 64'(result), 64'd8);

        // Reset in the middle of a run.
        @(negedge clock);
        start = 1'b1; key = 32'd17; mod = 32'd3233; plaintext = 32'd65;
        @(negedge clock);
        start = 1'b0;
        repeat (499) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("t6 busy_after_reset", 64'(busy), 64'd0);
        check("t6 result_after_reset", 64'(result), 64'd0);
        reset = 1'b0;
        pulses = 0;
        for (int c = 0; c < 1100; c++) begin
            @(negedge clock);
            if (done) pulses++;
        end
        check("t6 no_done_after_abort", 64'(pulses), 64'd0);
        check("t6 idle_after_abort", 64'(busy), 64'd0);
        run_op("t6_max", 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 1'b0, -1, -1, 1'b0);

        // Randomized operands against the model; every fourth is illegal.
        for (int t = 0; t < 10; t++) begin
            rk = $urandom;
            rm = $urandom | 32'h2;
            rp = (t % 4 == 3) ? rm : ($urandom % rm);
            model(rk, rm, rp, er, ee);
            run_op($sformatf("rand%0d", t), rk, rm, rp, er, ee, -1, -1, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
